// File: rtl/prio_dec16.sv
// Sequential 4-to-16 priority-code decoder: each accepted code drives a one-hot
// grant for HOLD_CYCLES cycles, with a one-deep pending buffer for back-to-back codes.
module prio_dec16 #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        V,
  input  logic [3:0]  Q,
  output logic        RDY,
  output logic [15:0] Y,
  output logic        ACT,
  output logic        DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       y_q, y_d;
  logic              pend_vld_q, pend_vld_d;
  logic [3:0]        pend_code_q, pend_code_d;
  logic              xfer_s;
  logic              final_s;

  assign RDY     = !rst && !pend_vld_q;
  assign xfer_s  = V && RDY;
  assign final_s = (state_q == HOLD) && (cnt_q == {CNT_W{1'b0}});
  assign Y       = y_q;
  assign ACT     = (state_q == HOLD);
  assign DONE    = final_s;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      y_q         <= 16'h0000;
      pend_vld_q  <= 1'b0;
      pend_code_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          y_d     = 16'h0001 << Q;
          cnt_d   = RELOAD;
          state_d = HOLD;
        end else begin
          y_d = 16'h0000;
        end
      end
      HOLD: begin
        if (!final_s) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (xfer_s) begin
            pend_vld_d  = 1'b1;
            pend_code_d = Q;
          end else begin
            pend_vld_d = pend_vld_q;
          end
        end else if (pend_vld_q) begin
          // Pending code takes over with no idle gap
          y_d        = 16'h0001 << pend_code_q;
          cnt_d      = RELOAD;
          pend_vld_d = 1'b0;
        end else if (xfer_s) begin
          y_d   = 16'h0001 << Q;
          cnt_d = RELOAD;
        end else begin
          y_d     = 16'h0000;
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        y_d        = 16'h0000;
        cnt_d      = {CNT_W{1'b0}};
        pend_vld_d = 1'b0;
      end
    endcase
  end

endmodule
